// File: rtl/aes_inv_round_ctrl_pkg.sv
// Shared definitions for the iterative AES-128 decryption engine.
// FSM encodings, sizes and GF(2^8) helpers used by the datapath.
package aes_inv_round_ctrl_pkg;

  localparam int AES_NR     = 10;
  localparam int AES_KIDX_W = 4;
  localparam int AES_BLK_W  = 128;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic logic [7:0] xtime(
    input logic [7:0] a
  );
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse, and maps 0 to 0
  function automatic logic [7:0] ginv(
    input logic [7:0] x
  );
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(
    input logic [7:0] x
  );
    logic [7:0] b;
    b = {x[6:0], x[7]}
      ^ {x[4:0], x[7:5]}
      ^ {x[1:0], x[7:2]}
      ^ 8'h05;
    return ginv(b);
  endfunction

endpackage

// File: rtl/aes_inv_round_ctrl_round.sv
// One inverse-cipher round, purely combinational.
// last=1 skips inv_mix_columns for the final round.
import aes_inv_round_ctrl_pkg::*;

module inv_shift_row (
  input  logic [0:AES_BLK_W-1] st_in,
  output logic [0:AES_BLK_W-1] st_out
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int SC = (c + 4 - r) % 4;
      assign st_out[32*c+8*r +: 8] =
        st_in[32*SC+8*r +: 8];
    end
  end
endmodule

module inv_sub_bytes (
  input  logic [0:AES_BLK_W-1] st_in,
  output logic [0:AES_BLK_W-1] st_out
);
  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign st_out[8*i +: 8] =
      inv_sbox(st_in[8*i +: 8]);
  end
endmodule

module inv_mix_columns (
  input  logic [0:AES_BLK_W-1] st_in,
  output logic [0:AES_BLK_W-1] st_out
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = st_in[32*c    +: 8];
    assign a1 = st_in[32*c+8  +: 8];
    assign a2 = st_in[32*c+16 +: 8];
    assign a3 = st_in[32*c+24 +: 8];
    assign st_out[32*c +: 8] =
      gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^
      gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
    assign st_out[32*c+8 +: 8] =
      gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^
      gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
    assign st_out[32*c+16 +: 8] =
      gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^
      gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
    assign st_out[32*c+24 +: 8] =
      gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^
      gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
  end
endmodule

module aes_inv_round (
  input  logic [0:AES_BLK_W-1] st_in,
  input  logic [0:AES_BLK_W-1] rkey,
  input  logic                 last,
  output logic [0:AES_BLK_W-1] st_out
);
  logic [0:AES_BLK_W-1] sr;
  logic [0:AES_BLK_W-1] sb;
  logic [0:AES_BLK_W-1] ak;
  logic [0:AES_BLK_W-1] mc;

  inv_shift_row u_isr (
    .st_in  (st_in),
    .st_out (sr)
  );

  inv_sub_bytes u_isb (
    .st_in  (sr),
    .st_out (sb)
  );

  assign ak = sb ^ rkey;

  inv_mix_columns u_imc (
    .st_in  (ak),
    .st_out (mc)
  );

  assign st_out = last ? ak : mc;
endmodule

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES-128 decryption controller: one round per clock.
// Addresses the expanded-key store by round index.
import aes_inv_round_ctrl_pkg::*;

module aes_inv_round_ctrl #(
  parameter int NR     = AES_NR,
  parameter int KIDX_W = AES_KIDX_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_ready,
  output logic [KIDX_W-1:0]    key_idx,
  input  logic [0:AES_BLK_W-1] round_key,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [0:AES_BLK_W-1] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [0:AES_BLK_W-1] out_data
);

  state_t               state;
  logic [KIDX_W-1:0]    rnd;
  logic [0:AES_BLK_W-1] st_reg;
  logic [0:AES_BLK_W-1] st_nxt;
  logic                 last;

  assign last = (rnd == '0);

  aes_inv_round u_round (
    .st_in  (st_reg),
    .rkey   (round_key),
    .last   (last),
    .st_out (st_nxt)
  );

  assign key_idx = (state == RUN) ?
    rnd : KIDX_W'(NR);
  assign in_ready = rst_n & key_ready &
    (state == IDLE);
  assign out_valid = rst_n & (state == DONE);
  assign out_data = out_valid ? st_reg : '0;

  // FSM, round counter and state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      rnd    <= '0;
      st_reg <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            st_reg <= in_data ^ round_key;
            rnd    <= KIDX_W'(NR - 1);
            state  <= RUN;
          end
        end
        RUN: begin
          if (key_ready) begin
            st_reg <= st_nxt;
            if (last) state <= DONE;
            else      rnd   <= rnd - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl: vector table plus corner sequences.
// Key store is the FIPS-197 C.1 key expanded by a forward model.
module tb_aes_inv_round_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_ready;
  logic [3:0]   key_idx;
  logic [127:0] round_key;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  int checks = 0;
  int failures = 0;

  logic [127:0] rk [0:15];

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FCT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FPT = 128'h00112233445566778899aabbccddeeff;

  typedef struct {
    logic [127:0] ct;
    logic [127:0] pt;
    int           stall;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  assign round_key = rk[key_idx];

  aes_inv_round_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_ready (key_ready),
    .key_idx   (key_idx),
    .round_key (round_key),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // forward S-box: brute-force inverse, then affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v, s;
    v = 8'h00;
    for (int y = 1; y < 256; y++)
      if (mul(x, 8'(y)) == 8'h01) v = 8'(y);
    s = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
          ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      s[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox(s[i]);
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          s[4*c+w] = t[4*((c+w)%4)+w];
      if (r < 10)
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = mul(a0, 8'h02) ^ mul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ mul(a1, 8'h02) ^ mul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ mul(a2, 8'h02) ^ mul(a3, 8'h03);
          s[4*c+3] = mul(a0, 8'h03) ^ a1 ^ a2 ^ mul(a3, 8'h02);
        end
      for (int i = 0; i < 16; i++)
        s[i] = s[i] ^ rk[r][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  task automatic expand_key();
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]),
             sbox(t[31:24])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // call at a negedge; returns at the negedge after the accept edge
  task automatic do_accept(input logic [127:0] ct);
    bit ok;
    ok = 0;
    in_data = ct;
    in_valid = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin ok = 1; break; end
      @(negedge clk); #1;
    end
    chk("accept_wait", 128'(ok), 128'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int stall, output int lat);
    bit stalled;
    lat = 1;
    stalled = 0;
    while (!out_valid && lat < 40) begin
      if (stall > 0 && !stalled && key_idx == 4'd5) begin
        stalled = 1;
        key_ready = 1'b0;
        repeat (stall) begin
          @(negedge clk);
          lat++;
          chk("stall_kidx", 128'(key_idx), 128'd5);
        end
        key_ready = 1'b1;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic send(input logic [127:0] ct, input logic [127:0] pt, input int stall);
    int lat;
    out_ready = 1'b1;
    do_accept(ct);
    wait_out(stall, lat);
    chk("latency", 128'(lat), 128'(11 + stall));
    chk("plaintext", out_data, pt);
    @(negedge clk);
    chk("one_pulse", 128'(out_valid), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int n_acc, n_out;
    int acc [2];
    logic [127:0] got [2];
    bit seen;

    rst_n = 1'b0;
    key_ready = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    expand_key();

    vecs[0] = '{FCT, FPT, 0};
    vecs[1] = '{FCT, FPT, 3};
    vecs[2] = '{'0, 128'h0, 0};
    vecs[3] = '{'0, {128{1'b1}}, 0};
    vecs[4] = '{'0, 128'h0123456789abcdeffedcba9876543210, 2};
    for (int k = 2; k < 5; k++) vecs[k].ct = enc(vecs[k].pt);

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_key_idx", 128'(key_idx), 128'd10);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 128'(in_ready), 128'd1);

    for (int k = 0; k < 5; k++)
      send(vecs[k].ct, vecs[k].pt, vecs[k].stall);

    // backpressure while a new ciphertext is offered
    out_ready = 1'b0;
    do_accept(FCT);
    wait_out(0, lat);
    chk("bp_latency", 128'(lat), 128'd11);
    in_valid = 1'b1;
    in_data = vecs[3].ct;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 128'(out_valid), 128'd1);
      chk("bp_data", out_data, FPT);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 128'(out_valid), 128'd0);
    chk("bp_release_ready", 128'(in_ready), 128'd1);

    // back-to-back with in_valid held high
    n_acc = 0; n_out = 0;
    acc[0] = 0; acc[1] = 0;
    got[0] = '0; got[1] = '0;
    in_data = FCT;
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 60 && n_out < 2; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (n_acc == 1) in_data = vecs[4].ct;
      if (n_acc == 2) in_valid = 1'b0;
      #1;
      if (in_valid && in_ready && n_acc < 2) begin
        acc[n_acc] = cyc; n_acc++;
      end
      if (out_valid) begin
        got[n_out] = out_data; n_out++;
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_accepts", 128'(n_acc), 128'd2);
    chk("b2b_outputs", 128'(n_out), 128'd2);
    chk("b2b_interval", 128'(acc[1] - acc[0]), 128'd12);
    chk("b2b_first", got[0], FPT);
    chk("b2b_second", got[1], vecs[4].pt);

    // reset in the middle of a block
    do_accept(FCT);
    for (int i = 0; i < 20; i++) begin
      if (key_idx == 4'd4) break;
      @(negedge clk);
    end
    chk("mid_kidx", 128'(key_idx), 128'd4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 128'(in_ready), 128'd0);
    @(negedge clk);
    chk("mid_rst_kidx", 128'(key_idx), 128'd10);
    chk("mid_rst_valid", 128'(out_valid), 128'd0);
    rst_n = 1'b1;
    #1;
    chk("mid_release_ready", 128'(in_ready), 128'd1);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("mid_no_output", 128'(seen), 128'd0);
    send(FCT, FPT, 0);

    // key store not ready while idle
    key_ready = 1'b0;
    in_data = FCT;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("kr_in_ready", 128'(in_ready), 128'd0);
      chk("kr_idle_kidx", 128'(key_idx), 128'd10);
    end
    key_ready = 1'b1;
    #1;
    chk("kr_raise_ready", 128'(in_ready), 128'd1);
    send(FCT, FPT, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
